// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with stall (hold) and flush (bubble, PC kept).
// Define STAGE_PERF_EN to build saturating stall/flush event counters; otherwise they read 0.
module pipe_stage_reg #(
   parameter int unsigned PC_W     = 32,
   parameter int unsigned INST_W   = 32,
   parameter int unsigned SIDE_W   = 8,
   parameter logic [31:0] RESET_PC = 32'h00003000,
   parameter logic [31:0] NOP_INST = 32'h00000000,
   parameter int unsigned CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic [PC_W-1:0]   flush_pc,
   input  logic [SIDE_W-1:0] flush_side,
   input  logic              in_valid,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [INST_W-1:0] in_inst,
   input  logic [SIDE_W-1:0] in_side,
   output logic              out_valid,
   output logic [PC_W-1:0]   out_pc,
   output logic [INST_W-1:0] out_inst,
   output logic [SIDE_W-1:0] out_side,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [PC_W-1:0]   RST_PC  = PC_W'(RESET_PC);
   localparam logic [INST_W-1:0] NOP_VAL = INST_W'(NOP_INST);

   // Bubbles keep a real PC so downstream exception/EPC logic stays correct.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_pc    <= RST_PC;
         out_inst  <= NOP_VAL;
         out_side  <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
         out_pc    <= flush_pc;
         out_inst  <= NOP_VAL;
         out_side  <= flush_side;
      end else if (!stall) begin
         out_valid <= in_valid;
         out_pc    <= in_pc;
         out_inst  <= in_inst;
         out_side  <= in_side;
      end
   end

`ifdef STAGE_PERF_EN
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] flush_q;

   // Counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else if (flush) begin
         if (flush_q != '1) flush_q <= flush_q + CNT_W'(1);
      end else if (stall) begin
         if (stall_q != '1) stall_q <= stall_q + CNT_W'(1);
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a default-width instance (CNT_W=4) and a narrow
// instance (PC_W=16, INST_W=24) sharing clk/rst/stall/flush.
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        rst, stall, flush;
   logic [31:0] flush_pc, in_pc, in_inst, out_pc, out_inst;
   logic [7:0]  flush_side, in_side, out_side;
   logic        in_valid, out_valid;
   logic [3:0]  stall_cnt, flush_cnt;

   logic [15:0] s_flush_pc, s_in_pc, s_out_pc;
   logic [23:0] s_in_inst, s_out_inst;
   logic [7:0]  s_flush_side, s_in_side, s_out_side;
   logic        s_in_valid, s_out_valid;
   logic [3:0]  s_stall_cnt, s_flush_cnt;

   int numVectors = 0;
   int numMiscompares = 0;

`ifdef STAGE_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   always #5 clk = ~clk;

   pipe_stage_reg #(.CNT_W(4)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .flush_pc(flush_pc), .flush_side(flush_side),
      .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_side(in_side),
      .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_side(out_side),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipe_stage_reg #(.PC_W(16), .INST_W(24), .RESET_PC(32'h00001234),
                    .NOP_INST(32'hFF000013), .CNT_W(4)) dutSmall (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .flush_pc(s_flush_pc), .flush_side(s_flush_side),
      .in_valid(s_in_valid), .in_pc(s_in_pc), .in_inst(s_in_inst), .in_side(s_in_side),
      .out_valid(s_out_valid), .out_pc(s_out_pc), .out_inst(s_out_inst), .out_side(s_out_side),
      .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      numVectors++;
      if (observed !== expected) begin
         numMiscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drive controls and main-instance inputs, then sample 1 time unit after the edge.
   task automatic applyStimulus(input logic r, input logic s, input logic f,
                                input logic v, input logic [31:0] pc,
                                input logic [31:0] inst, input logic [7:0] side);
      rst = r; stall = s; flush = f;
      in_valid = v; in_pc = pc; in_inst = inst; in_side = side;
      @(posedge clk);
      #1;
   endtask

   task automatic checkMain(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] inst, input logic [7:0] side);
      checkOutput({tag, ".valid"}, 64'(out_valid), 64'(v));
      checkOutput({tag, ".pc"},    64'(out_pc),    64'(pc));
      checkOutput({tag, ".inst"},  64'(out_inst),  64'(inst));
      checkOutput({tag, ".side"},  64'(out_side),  64'(side));
   endtask

   task automatic checkCounters(input string tag, input int sc, input int fc);
      checkOutput({tag, ".stall_cnt"}, 64'(stall_cnt), PERF ? 64'(sc) : 64'd0);
      checkOutput({tag, ".flush_cnt"}, 64'(flush_cnt), PERF ? 64'(fc) : 64'd0);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      flush_pc = '0; flush_side = '0;
      in_valid = 1'b0; in_pc = '0; in_inst = '0; in_side = '0;
      s_flush_pc = 16'h0; s_flush_side = 8'h0;
      s_in_valid = 1'b0; s_in_pc = 16'h0; s_in_inst = 24'h0; s_in_side = 8'h0;
      @(negedge clk);

      // Reset: values appear even though inputs are busy
      applyStimulus(1, 0, 0, 1, 32'hDEAD0000, 32'hFFFFFFFF, 8'hAA);
      checkMain("reset", 0, 32'h00003000, 32'h0, 8'h0);
      checkCounters("reset", 0, 0);
      checkOutput("small.reset.pc",   64'(s_out_pc),   64'h1234);
      checkOutput("small.reset.inst", 64'(s_out_inst), 64'h000013);

      // Load
      s_in_valid = 1'b1; s_in_pc = 16'h5678; s_in_inst = 24'hABCDEF; s_in_side = 8'h3C;
      applyStimulus(0, 0, 0, 1, 32'h00003004, 32'h24080001, 8'h00);
      checkMain("load", 1, 32'h00003004, 32'h24080001, 8'h00);
      checkOutput("small.load.valid", 64'(s_out_valid), 64'd1);
      checkOutput("small.load.pc",    64'(s_out_pc),    64'h5678);
      checkOutput("small.load.inst",  64'(s_out_inst),  64'hABCDEF);
      checkOutput("small.load.side",  64'(s_out_side),  64'h3C);

      // Stall for 3 cycles with new inputs waiting
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1, 0, 1, 32'h00003008, 32'h24090002, 8'h05);
         checkMain($sformatf("stall%0d", i), 1, 32'h00003004, 32'h24080001, 8'h00);
      end
      checkOutput("small.stall.inst", 64'(s_out_inst), 64'hABCDEF);
      checkCounters("stall", 3, 0);

      // Release stall
      applyStimulus(0, 0, 0, 1, 32'h00003008, 32'h24090002, 8'h05);
      checkMain("release", 1, 32'h00003008, 32'h24090002, 8'h05);

      // Flush beats a simultaneous stall
      flush_pc = 32'h0000300C; flush_side = 8'h01;
      s_flush_pc = 16'h0ACE; s_flush_side = 8'h02;
      applyStimulus(0, 1, 1, 1, 32'h00003010, 32'h11111111, 8'h77);
      checkMain("flush+stall", 0, 32'h0000300C, 32'h0, 8'h01);
      checkCounters("flush+stall", 3, 1);
      checkOutput("small.flush.pc",   64'(s_out_pc),   64'h0ACE);
      checkOutput("small.flush.inst", 64'(s_out_inst), 64'h000013);
      checkOutput("small.flush.side", 64'(s_out_side), 64'h02);

      // Stall while holding a bubble keeps the bubble
      applyStimulus(0, 1, 0, 1, 32'h00003014, 32'h22222222, 8'h66);
      checkMain("bubble-stall", 0, 32'h0000300C, 32'h0, 8'h01);
      checkCounters("bubble-stall", 4, 1);

      // in_valid=0 still loads the other fields
      applyStimulus(0, 0, 0, 0, 32'h00003018, 32'h1234ABCD, 8'h7E);
      checkMain("load-invalid", 0, 32'h00003018, 32'h1234ABCD, 8'h7E);

      // Plain flush replaces a real instruction with NOP
      applyStimulus(0, 0, 0, 1, 32'h0000301C, 32'h33333333, 8'h10);
      flush_pc = 32'h00004000; flush_side = 8'h80;
      applyStimulus(0, 0, 1, 1, 32'h00003020, 32'h44444444, 8'h20);
      checkMain("flush", 0, 32'h00004000, 32'h0, 8'h80);
      checkCounters("flush", 4, 2);

      // Reset overrides flush and stall together
      applyStimulus(1, 1, 1, 1, 32'h00003024, 32'h55555555, 8'h30);
      checkMain("rst+flush+stall", 0, 32'h00003000, 32'h0, 8'h00);
      checkCounters("rst+flush+stall", 0, 0);
      checkOutput("small.rst.pc", 64'(s_out_pc), 64'h1234);

      // Counter saturation: 20 stalls, then 2 flushes
      for (int i = 0; i < 20; i++)
         applyStimulus(0, 1, 0, 1, 32'h00005000, 32'h66666666, 8'h01);
      checkCounters("stall-sat", 15, 0);
      checkMain("stall-sat", 0, 32'h00003000, 32'h0, 8'h00);
      for (int i = 0; i < 2; i++)
         applyStimulus(0, 0, 1, 1, 32'h00005000, 32'h66666666, 8'h01);
      checkCounters("flush2", 15, 2);

      // Flush counter saturates too
      for (int i = 0; i < 16; i++)
         applyStimulus(0, 0, 1, 1, 32'h00005000, 32'h66666666, 8'h01);
      checkCounters("flush-sat", 15, 15);

      $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register, the successor to the fixed F→D latch.
- Carries a valid bit, PC, instruction word and a sideband field (exception code / flags) between any two adjacent pipeline stages.
- Adds stall (hold), flush (bubble with preserved PC) and optional stall/flush performance counters.
- One instance per stage boundary (F/D, D/E, E/M, M/W).

Parameters:
- PC_W, 32, width of the PC field.
- INST_W, 32, width of the instruction field.
- SIDE_W, 8, width of the sideband field (exception code, delay-slot flag, etc.); must be ≥1.
- RESET_PC, 32'h00003000, out_pc value after reset (truncated/zero-extended to PC_W).
- NOP_INST, 32'h00000000, instruction value loaded on reset or flush (truncated to INST_W).
- CNT_W, 16, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- stall  in  1  hold the current contents
- flush  in  1  replace the contents with a bubble
- flush_pc  in  PC_W  PC written to the bubble on flush
- flush_side  in  SIDE_W  sideband written to the bubble on flush
- in_valid  in  1  upstream slot holds a real instruction
- in_pc  in  PC_W  upstream PC
- in_inst  in  INST_W  upstream instruction
- in_side  in  SIDE_W  upstream sideband
- out_valid  out  1  registered valid
- out_pc  out  PC_W  registered PC
- out_inst  out  INST_W  registered instruction
- out_side  out  SIDE_W  registered sideband
- stall_cnt  out  CNT_W  count of stalled cycles (optional feature)
- flush_cnt  out  CNT_W  count of flush events (optional feature)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on rst. All state updates occur on the rising edge of clk.
- Per-edge priority, highest first: rst > flush > stall > load.
- rst: out_valid=0, out_pc=RESET_PC, out_inst=NOP_INST, out_side=0, counters=0.
- flush (rst=0): out_valid=0, out_pc=flush_pc, out_inst=NOP_INST, out_side=flush_side.
  - The PC is kept so that exception and EPC logic downstream sees a correct PC for the bubble.
  - flush overrides a simultaneous stall.
- stall (rst=0, flush=0): all outputs hold their previous values.
- load (rst=0, flush=0, stall=0): outputs take in_valid, in_pc, in_inst, in_side. in_valid=0 still loads the PC, instruction and sideband fields unchanged.
- Latency: exactly 1 cycle from input to output. No combinational path from any input to any output.
- Stall does not inspect in_valid; a stall while out_valid=0 holds the bubble.
- Reset asserted mid-stall or mid-flush takes effect on that same edge; no state survives.
- Outputs are plain registers; there are no X-producing paths after the first reset edge.

Optional Feature:
- Macro: STAGE_PERF_EN.
- Defined:
  - stall_cnt increments on each edge with rst=0, flush=0, stall=1.
  - flush_cnt increments on each edge with rst=0, flush=1.
  - Both counters saturate at 2^CNT_W−1 (no wrap).
  - Both clear only on rst.
- Undefined: no counter registers are built; stall_cnt and flush_cnt are tied to 0. All other behaviour is identical.

Test Plan:
- Reset → out_valid=0, out_pc=32'h00003000, out_inst=0, out_side=0. Then load in_pc=32'h3004, in_inst=32'h24080001, in_valid=1 → next cycle outputs equal the inputs, out_valid=1.
- Hold stall=1 for 3 cycles while the inputs change to in_pc=32'h3008 → outputs stay 32'h3004/32'h24080001. Release stall → 32'h3008 appears 1 cycle later.
- flush=1 and stall=1 together, flush_pc=32'h300c, flush_side=8'h01 → out_valid=0, out_pc=32'h300c, out_inst=0, out_side=8'h01.
- rst=1 in the same cycle as flush=1 and stall=1 → reset values win (out_pc=32'h00003000, out_side=0).
- Instance with PC_W=16, INST_W=24, RESET_PC=32'h1234 → after reset out_pc=16'h1234; a load of in_inst=24'hABCDEF propagates intact.
- With STAGE_PERF_EN and CNT_W=4: drive 20 stall cycles then 2 flushes → stall_cnt=15 (saturated), flush_cnt=2. Without the macro both counters read 0.
